// File: rtl/ecc_53_scrubber.sv
// Background scrubber for the SECDED-protected FIFO RAM, plus the 53/7 SECDED codec it decodes through.
// Each word is read, checked, rewritten if correctable, and logged if it is not.

module ecc_53_top (
    input  logic [52:0] data_in,
    input  logic [6:0]  parity_in,
    input  logic        bypass,
    output logic [52:0] data_out,
    output logic [6:0]  parity_out,
    output logic        sbit_err,
    output logic        dbit_err
);
    // Odd-weight columns: data bit k sits at the k-th non-power-of-two Hamming position,
    // with bit 6 chosen so every column has odd weight (singles odd, doubles even).
    function automatic logic [52:0][6:0] gen_cols();
        logic [52:0][6:0] c;
        logic [6:0]       p;
        int               k;
        c = '0;
        k = 0;
        for (int i = 3; i < 64; i++) begin
            p = 7'(i);
            if (((p & (p - 7'd1)) != 7'd0) && (k < 53)) begin
                c[k] = {~^p[5:0], p[5:0]};
                k++;
            end
        end
        return c;
    endfunction

    localparam logic [52:0][6:0] COLS = gen_cols();

    function automatic logic [6:0] enc(input logic [52:0] d);
        logic [6:0] p;
        p = '0;
        for (int j = 0; j < 53; j++)
            if (d[j]) p = p ^ COLS[j];
        return p;
    endfunction

    logic [6:0]  syn;
    logic [52:0] mask;

    always_comb begin
        syn  = parity_in ^ enc(data_in);
        mask = '0;
        for (int j = 0; j < 53; j++)
            if (syn == COLS[j]) mask[j] = ^syn;
    end

    assign sbit_err   = !bypass && (^syn);
    assign dbit_err   = !bypass && (syn != 7'd0) && !(^syn);
    assign data_out   = bypass ? data_in : (data_in ^ mask);
    assign parity_out = enc(data_out);
endmodule

module ecc_53_scrubber #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int DATA_WIDTH   = 53,
    parameter int PARITY_WIDTH = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [15:0]                          interval,
    input  logic                                 clr_cnt,
    output logic                                 mem_req,
    input  logic                                 mem_gnt,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH+PARITY_WIDTH-1:0]   mem_rdata,
    output logic                                 busy,
    output logic                                 done,
    output logic [15:0]                          sbit_cnt,
    output logic [15:0]                          dbit_cnt,
    output logic                                 dbit_seen,
    output logic [ADDR_WIDTH-1:0]                first_dbit_addr
);
    // state     | meaning
    // S_IDLE    | parked, waiting for enable
    // S_WAIT    | inter-word gap, counting interval down to 1
    // S_RD_REQ  | read request held until granted
    // S_RD_DATA | capture read word
    // S_CHECK   | decode captured word, count/log errors
    // S_WB_REQ  | write-back of corrected word held until granted
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD_REQ, S_RD_DATA, S_CHECK, S_WB_REQ} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                              state;
    logic [ADDR_WIDTH-1:0]               addr;
    logic [ADDR_WIDTH-1:0]               next_addr;
    logic [15:0]                         wait_cnt;
    logic [DATA_WIDTH+PARITY_WIDTH-1:0]  rdata_q;
    logic [DATA_WIDTH-1:0]               corr_data;
    logic [PARITY_WIDTH-1:0]             corr_parity;
    logic                                sbit_err;
    logic                                dbit_err;
    logic                                word_end;
    logic                                sbit_inc;
    logic                                dbit_inc;

    ecc_53_top u_ecc (
        .data_in    (rdata_q[DATA_WIDTH-1:0]),
        .parity_in  (rdata_q[DATA_WIDTH+PARITY_WIDTH-1:DATA_WIDTH]),
        .bypass     (1'b0),
        .data_out   (corr_data),
        .parity_out (corr_parity),
        .sbit_err   (sbit_err),
        .dbit_err   (dbit_err)
    );

    assign busy      = (state != S_IDLE);
    assign next_addr = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    assign word_end  = ((state == S_CHECK) && !sbit_err) || ((state == S_WB_REQ) && mem_gnt);
    assign sbit_inc  = (state == S_CHECK) && sbit_err;
    assign dbit_inc  = (state == S_CHECK) && dbit_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            addr            <= '0;
            wait_cnt        <= '0;
            rdata_q         <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            done            <= 1'b0;
            sbit_cnt        <= '0;
            dbit_cnt        <= '0;
            dbit_seen       <= 1'b0;
            first_dbit_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (enable) begin
                    state    <= S_RD_REQ;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= addr;
                end
                S_WAIT: if (wait_cnt == 16'd1) begin
                    state    <= S_RD_REQ;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= addr;
                end else begin
                    wait_cnt <= wait_cnt - 16'd1;
                end
                S_RD_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    state   <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    rdata_q <= mem_rdata;
                    state   <= S_CHECK;
                end
                S_CHECK: if (sbit_err) begin
                    state     <= S_WB_REQ;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= {corr_parity, corr_data};
                end
                S_WB_REQ: if (mem_gnt) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            // Shared end-of-word handling overrides the per-state next state.
            if (word_end) begin
                addr <= next_addr;
                done <= (addr == LAST_ADDR);
                if (!enable) begin
                    state <= S_IDLE;
                end else if (interval != 16'd0) begin
                    state    <= S_WAIT;
                    wait_cnt <= interval;
                end else begin
                    state    <= S_RD_REQ;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= next_addr;
                end
            end

            if (clr_cnt) begin
                sbit_cnt        <= '0;
                dbit_cnt        <= '0;
                dbit_seen       <= 1'b0;
                first_dbit_addr <= '0;
            end else begin
                if (sbit_inc && (sbit_cnt != 16'hFFFF)) sbit_cnt <= sbit_cnt + 16'd1;
                if (dbit_inc && (dbit_cnt != 16'hFFFF)) dbit_cnt <= dbit_cnt + 16'd1;
                if (dbit_inc && !dbit_seen) begin
                    dbit_seen       <= 1'b1;
                    first_dbit_addr <= addr;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecc_53_scrubber.sv
// Directed bench for ecc_53_scrubber on a 4-word RAM model with hand-computed SECDED words.
module tb_ecc_53_scrubber;
    logic        clk = 1'b0;
    logic        rst, enable, clr_cnt, mem_gnt;
    logic [15:0] interval;
    logic        mem_req, mem_we, busy, done, dbit_seen;
    logic [7:0]  mem_addr, first_dbit_addr;
    logic [59:0] mem_wdata, mem_rdata;
    logic [15:0] sbit_cnt, dbit_cnt;

    ecc_53_scrubber #(.ADDR_WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .interval(interval), .clr_cnt(clr_cnt),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .dbit_seen(dbit_seen),
        .first_dbit_addr(first_dbit_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Clean codewords: data 0..3 with parity = xor of the columns of the set data bits.
    localparam logic [59:0] W0 = 60'h0;
    localparam logic [59:0] W1 = {7'b1000011, 53'd1};
    localparam logic [59:0] W2 = {7'b1000101, 53'd2};
    localparam logic [59:0] W3 = {7'b0000110, 53'd3};

    logic [3:0][59:0] mem, load_words;
    logic             load = 1'b0;
    int               nwr;
    logic [7:0]       wr_addr;
    logic [59:0]      wr_data;

    always @(posedge clk) begin
        if (load) begin
            mem <= load_words;
            nwr <= 0;
        end else if (mem_req && mem_gnt) begin
            if (mem_we) begin
                mem[mem_addr[1:0]] <= mem_wdata;
                nwr     <= nwr + 1;
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr[1:0]];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0][59:0] words);
        load_words = words;
        load       = 1'b1;
        rst        = 1'b1;
        enable     = 1'b0;
        clr_cnt    = 1'b0;
        mem_gnt    = 1'b1;
        interval   = 16'd0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic run_pass(input int stall_rd, input int stall_wb, output int done_at, output int first_req);
        int         stall, c0;
        bit         rd_done, wb_done;
        logic [9:0] snap_ctl;
        logic [59:0] snap_wd;
        stall = 0; rd_done = 0; wb_done = 0; done_at = -1; first_req = -1;
        snap_ctl = '0; snap_wd = '0;
        enable = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 300 && done_at < 0; i++) begin
            @(negedge clk);
            if (mem_req && first_req < 0) first_req = cyc - c0;
            if (stall > 0) begin
                chk("stall_ctl", {54'd0, mem_req, mem_we, mem_addr}, {54'd0, snap_ctl});
                chk("stall_wdata", {4'd0, mem_wdata}, {4'd0, snap_wd});
                stall--;
                if (stall == 0) mem_gnt = 1'b1;
            end else if (mem_req && !mem_we && int'(mem_addr) == stall_rd && !rd_done) begin
                rd_done = 1; snap_ctl = {mem_req, mem_we, mem_addr}; snap_wd = mem_wdata;
                mem_gnt = 1'b0; stall = 5;
            end else if (mem_req && mem_we && int'(mem_addr) == stall_wb && !wb_done) begin
                wb_done = 1; snap_ctl = {mem_req, mem_we, mem_addr}; snap_wd = mem_wdata;
                mem_gnt = 1'b0; stall = 5;
            end
            if (done) done_at = cyc - c0;
        end
        enable = 1'b0;
        if (done_at < 0) chk("done_timeout", 0, 1);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk("idle_after_pass", {63'd0, busy}, 0);
    endtask

    typedef struct {
        logic [3:0][59:0] words;
        int               stall_rd;
        int               stall_wb;
        int               exp_done;
        int               exp_nwr;
        int               exp_wr_addr;
        logic [59:0]      exp_wr_data;
        int               exp_sbit;
        int               exp_dbit;
        int               exp_seen;
        int               exp_first;
        bit               do_clr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int d, f, r1, r2, c0;
        bit prev;

        vecs[0] = '{{W3, W2, W1, W0}, -1, -1, 13, 0, 0, 60'h0, 0, 0, 0, 0, 1'b0};
        vecs[1] = '{{W3, {7'b1000101, 53'd3}, W1, W0}, -1, -1, 14, 1, 2, W2, 1, 0, 0, 0, 1'b0};
        vecs[2] = '{{W3, W2, {7'b1000010, 53'd1}, W0}, -1, -1, 14, 1, 1, W1, 1, 0, 0, 0, 1'b0};
        vecs[3] = '{{{7'b0000110, 53'd0}, W2, {7'b1000011, 53'd2}, W0}, -1, -1, 13, 0, 0, 60'h0, 0, 2, 1, 1, 1'b1};
        vecs[4] = '{{W3, {7'b1000101, 53'd3}, W1, W0}, 1, 2, 24, 1, 2, W2, 1, 0, 0, 0, 1'b0};

        // Reset state
        rst = 1'b1; enable = 1'b0; clr_cnt = 1'b0; mem_gnt = 1'b1; interval = 16'd0;
        load_words = {W3, W2, W1, W0}; load = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {23'd0, mem_req, mem_we, mem_addr, busy, done, sbit_cnt, dbit_cnt, dbit_seen, first_dbit_addr}, 0);
        chk("rst_wdata", {4'd0, mem_wdata}, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset(vecs[i].words);
            run_pass(vecs[i].stall_rd, vecs[i].stall_wb, d, f);
            chk($sformatf("v%0d first_req", i), f, 1);
            chk($sformatf("v%0d done_cycle", i), d, vecs[i].exp_done);
            chk($sformatf("v%0d writes", i), nwr, vecs[i].exp_nwr);
            if (vecs[i].exp_nwr > 0) begin
                chk($sformatf("v%0d wr_addr", i), {56'd0, wr_addr}, vecs[i].exp_wr_addr);
                chk($sformatf("v%0d wr_data", i), {4'd0, wr_data}, {4'd0, vecs[i].exp_wr_data});
            end
            chk($sformatf("v%0d sbit_cnt", i), {48'd0, sbit_cnt}, vecs[i].exp_sbit);
            chk($sformatf("v%0d dbit_cnt", i), {48'd0, dbit_cnt}, vecs[i].exp_dbit);
            chk($sformatf("v%0d dbit_seen", i), {63'd0, dbit_seen}, vecs[i].exp_seen);
            chk($sformatf("v%0d first_dbit", i), {56'd0, first_dbit_addr}, vecs[i].exp_first);
            if (vecs[i].do_clr) begin
                clr_cnt = 1'b1;
                @(negedge clk);
                clr_cnt = 1'b0;
                chk("clr_all", {31'd0, sbit_cnt, dbit_cnt, dbit_seen, first_dbit_addr}, 0);
            end
        end

        // Enable dropped during the read of a correctable word: write-back still completes.
        do_reset({W3, W2, W1, {7'b0, 53'd1}});
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("drop_busy_check", {63'd0, busy}, 1);
        @(negedge clk);
        chk("drop_wb_req", {62'd0, mem_req, mem_we}, 3);
        @(negedge clk);
        chk("drop_idle", {63'd0, busy}, 0);
        chk("drop_writes", nwr, 1);
        chk("drop_wr_data", {4'd0, wr_data}, 0);
        enable = 1'b1;
        @(negedge clk);
        chk("resume_addr", {55'd0, mem_req, mem_addr}, {55'd0, 1'b1, 8'd1});
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);

        // interval = 3: second read request 3 cycles later than back-to-back.
        do_reset({W3, W2, W1, W0});
        interval = 16'd3;
        enable = 1'b1;
        c0 = cyc; r1 = -1; r2 = -1; prev = 1'b0;
        for (int i = 0; i < 40 && r2 < 0; i++) begin
            @(negedge clk);
            if (mem_req && !prev) begin
                if (r1 < 0) r1 = cyc - c0;
                else r2 = cyc - c0;
            end
            prev = mem_req;
        end
        chk("intv_first_req", r1, 1);
        chk("intv_second_req", r2, 7);
        enable = 1'b0;
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);

        // Reset while a write-back is pending.
        do_reset({W3, W2, W1, {7'b0, 53'd1}});
        enable = 1'b1;
        for (int i = 0; i < 20 && !(mem_req && mem_we); i++) @(negedge clk);
        chk("wb_reached", {62'd0, mem_req, mem_we}, 3);
        mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wb_ctl", {23'd0, mem_req, mem_we, mem_addr, busy, done, sbit_cnt, dbit_cnt, dbit_seen, first_dbit_addr}, 0);
        chk("rst_wb_wdata", {4'd0, mem_wdata}, 0);
        rst = 1'b0; enable = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
